// File: rtl/gray_mult_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// gray_mult_seq_ctrl_if
// Bundles the pixel-in, multiplier and gray-out handshake signals of the
// grayscale sequencer so that they can be passed around as one port.
//   slave  : seen by the sequencer (gray_mult_seq_ctrl)
//   master : seen by the environment (pixel source, multiplier, sink)
// Signal groups:
//   pix_*        : RGB pixel in, valid/ready
//   mult_*       : operands/enable out, products/done in
//   gray_*       : saturated gray value out, valid/ready, frame_last_o
//   busy_o, err_timeout_o, err_clr_i : status and sticky error control
// -----------------------------------------------------------------------------
interface gray_mult_seq_ctrl_if #(
  parameter int DATA_W = 24
);
  logic              pix_valid_i;
  logic              pix_ready_o;
  logic [DATA_W-1:0] pix_R_i;
  logic [DATA_W-1:0] pix_G_i;
  logic [DATA_W-1:0] pix_B_i;
  logic              mult_en_o;
  logic [DATA_W-1:0] mult_R_o;
  logic [DATA_W-1:0] mult_G_o;
  logic [DATA_W-1:0] mult_B_o;
  logic [DATA_W-1:0] mult_res_R_i;
  logic [DATA_W-1:0] mult_res_G_i;
  logic [DATA_W-1:0] mult_res_B_i;
  logic              mult_done_i;
  logic              gray_valid_o;
  logic              gray_ready_i;
  logic [DATA_W-1:0] gray_o;
  logic              frame_last_o;
  logic              busy_o;
  logic              err_timeout_o;
  logic              err_clr_i;

  modport slave (
    input  pix_valid_i, pix_R_i, pix_G_i, pix_B_i,
    input  mult_res_R_i, mult_res_G_i, mult_res_B_i, mult_done_i,
    input  gray_ready_i, err_clr_i,
    output pix_ready_o, mult_en_o, mult_R_o, mult_G_o, mult_B_o,
    output gray_valid_o, gray_o, frame_last_o, busy_o, err_timeout_o
  );

  modport master (
    output pix_valid_i, pix_R_i, pix_G_i, pix_B_i,
    output mult_res_R_i, mult_res_G_i, mult_res_B_i, mult_done_i,
    output gray_ready_i, err_clr_i,
    input  pix_ready_o, mult_en_o, mult_R_o, mult_G_o, mult_B_o,
    input  gray_valid_o, gray_o, frame_last_o, busy_o, err_timeout_o
  );
endinterface

// File: rtl/gray_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gray_mult_seq_ctrl
// Sequencer between the pixel source and the three-channel constant
// multiplier of the grayscale path. Accepts one RGB pixel, drives the
// multiplier until done (or until a stall timeout aborts the pixel), sums
// the three products into a saturated gray value and hands it downstream.
// Tracks the position within a frame and flags the last pixel.
//
// Ports:
//   clk_i_gray_ctrl  : clock, all state changes on the rising edge
//   rstn_i_gray_ctrl : synchronous active-low reset
//   bus (slave)      : pixel in, multiplier operands/products, gray out,
//                      busy/err_timeout status and err_clr_i
//
// Optional build macro GRAY_MULT_SEQ_ROUND_EN: adds parameter FRAC_W and
// rounds half-up at bit FRAC_W-1, clearing the low FRAC_W bits of gray_o.
// -----------------------------------------------------------------------------
module gray_mult_seq_ctrl #(
  parameter int DATA_W           = 24,
  parameter int TIMEOUT          = 64,
  parameter int PIXELS_PER_FRAME = 16
`ifdef GRAY_MULT_SEQ_ROUND_EN
  ,
  parameter int FRAC_W           = 16
`endif
) (
  input logic                 clk_i_gray_ctrl,
  input logic                 rstn_i_gray_ctrl,
  gray_mult_seq_ctrl_if.slave bus
);

  localparam int PIX_CNT_W = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
  localparam int TO_CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [PIX_CNT_W-1:0] PIX_LAST  = PIX_CNT_W'(PIXELS_PER_FRAME - 1);
  // Abort on the cycle whose increment would reach TIMEOUT-1, i.e. after
  // TIMEOUT-1 cycles in MULT without done.
  localparam logic [TO_CNT_W-1:0]  TO_ABORT  = TO_CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    SUM  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                state_r;
  logic [PIX_CNT_W-1:0]  pix_cnt_r;
  logic [TO_CNT_W-1:0]   to_cnt_r;
  logic [DATA_W-1:0]     res_r_r;
  logic [DATA_W-1:0]     res_g_r;
  logic [DATA_W-1:0]     res_b_r;
  logic [DATA_W-1:0]     mult_r_r;
  logic [DATA_W-1:0]     mult_g_r;
  logic [DATA_W-1:0]     mult_b_r;
  logic [DATA_W-1:0]     gray_r;
  logic                  mult_en_r;
  logic                  gray_valid_r;
  logic                  frame_last_r;
  logic                  busy_r;
  logic                  err_timeout_r;
  logic                  pix_ready_s;
  logic [DATA_W-1:0]     gray_sum_s;

  // Saturating three-way sum; the two guard bits catch any carry out.
  function automatic logic [DATA_W-1:0] sat_sum3(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c
  );
    logic [DATA_W+1:0] sum_v;
    logic [DATA_W-1:0] res_v;
    sum_v = {2'b00, a} + {2'b00, b} + {2'b00, c};
`ifdef GRAY_MULT_SEQ_ROUND_EN
    sum_v = sum_v + ((DATA_W+2)'(1) << FRAC_W-1);
`endif
    if (|sum_v[DATA_W+1:DATA_W]) begin
      res_v = '1;
    end else begin
      res_v = sum_v[DATA_W-1:0];
    end
`ifdef GRAY_MULT_SEQ_ROUND_EN
    res_v = res_v & ~((DATA_W'(1) << FRAC_W) - DATA_W'(1));
`endif
    return res_v;
  endfunction

  // Gray value computed from the latched products, captured in SUM.
  assign gray_sum_s = sat_sum3(res_r_r, res_g_r, res_b_r);

  // A done still high from the previous pixel blocks acceptance.
  assign pix_ready_s = (state_r == IDLE) && !bus.mult_done_i;

  // Sequencer FSM with all registered outputs and counters.
  always_ff @(posedge clk_i_gray_ctrl) begin
    if (!rstn_i_gray_ctrl) begin
      state_r       <= IDLE;
      pix_cnt_r     <= '0;
      to_cnt_r      <= '0;
      res_r_r       <= '0;
      res_g_r       <= '0;
      res_b_r       <= '0;
      mult_r_r      <= '0;
      mult_g_r      <= '0;
      mult_b_r      <= '0;
      gray_r        <= '0;
      mult_en_r     <= 1'b0;
      gray_valid_r  <= 1'b0;
      frame_last_r  <= 1'b0;
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      // Clear first; a timeout set further down in the same cycle overrides.
      if (bus.err_clr_i) begin
        err_timeout_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (bus.pix_valid_i && pix_ready_s) begin
            mult_r_r  <= bus.pix_R_i;
            mult_g_r  <= bus.pix_G_i;
            mult_b_r  <= bus.pix_B_i;
            to_cnt_r  <= '0;
            mult_en_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= MULT;
          end
        end

        MULT: begin
          // Done takes priority over the terminal count.
          if (bus.mult_done_i) begin
            res_r_r   <= bus.mult_res_R_i;
            res_g_r   <= bus.mult_res_G_i;
            res_b_r   <= bus.mult_res_B_i;
            mult_en_r <= 1'b0;
            state_r   <= SUM;
          end else if (to_cnt_r == TO_ABORT) begin
            err_timeout_r <= 1'b1;
            mult_en_r     <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_CNT_W'(1);
          end
        end

        SUM: begin
          gray_r       <= gray_sum_s;
          frame_last_r <= (pix_cnt_r == PIX_LAST);
          gray_valid_r <= 1'b1;
          state_r      <= OUT;
        end

        OUT: begin
          if (bus.gray_ready_i) begin
            gray_valid_r <= 1'b0;
            frame_last_r <= 1'b0;
            busy_r       <= 1'b0;
            pix_cnt_r    <= (pix_cnt_r == PIX_LAST) ? '0 : pix_cnt_r + PIX_CNT_W'(1);
            state_r      <= IDLE;
          end
        end

        default: begin
          mult_en_r    <= 1'b0;
          gray_valid_r <= 1'b0;
          frame_last_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.pix_ready_o   = pix_ready_s;
  assign bus.mult_en_o     = mult_en_r;
  assign bus.mult_R_o      = mult_r_r;
  assign bus.mult_G_o      = mult_g_r;
  assign bus.mult_B_o      = mult_b_r;
  assign bus.gray_valid_o  = gray_valid_r;
  assign bus.gray_o        = gray_r;
  assign bus.frame_last_o  = frame_last_r;
  assign bus.busy_o        = busy_r;
  assign bus.err_timeout_o = err_timeout_r;

endmodule
